// File: rtl/insn_buffer.sv
// Dual-issue instruction queue between fetch and decode: up to two instructions
// in and two out per cycle, strictly in program order, emptied by flush.
module insn_buffer #(
    parameter int DEPTH  = 8,
    parameter int PTAB_W = 5
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              flush,
    input  logic              if_ib_valid,
    input  logic [1:0]        if_ib_slot_valid,
    input  logic [31:0]       if_ib_pc_0,
    input  logic [31:0]       if_ib_pc_1,
    input  logic [31:0]       if_ib_insn_0,
    input  logic [31:0]       if_ib_insn_1,
    input  logic [PTAB_W-1:0] if_ib_ptab_addr_0,
    input  logic [PTAB_W-1:0] if_ib_ptab_addr_1,
    input  logic [1:0]        if_ib_delot_flag,
    output logic              ib_allin,
    input  logic              id_allin,
    output logic              ib_valid_ns,
    output logic [31:0]       ib_id_pc_0,
    output logic [31:0]       ib_id_pc_1,
    output logic [31:0]       ib_id_insn_0,
    output logic [31:0]       ib_id_insn_1,
    output logic [PTAB_W-1:0] ib_id_ptab_addr_0,
    output logic [PTAB_W-1:0] ib_id_ptab_addr_1,
    output logic              ib_id_valid_0,
    output logic              ib_id_valid_1,
    output logic [1:0]        ib_id_delot_flag
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]       pcMem_q   [DEPTH];
    logic [31:0]       insnMem_q [DEPTH];
    logic [PTAB_W-1:0] ptabMem_q [DEPTH];
    logic [DEPTH-1:0]  delotMem_q;

    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW-1:0] headNext, tailNext;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] pushCnt, popCnt;
    logic          pushEn, pushTwo, popEn;

    assign headNext = head_q + AW'(1);
    assign tailNext = tail_q + AW'(1);

    // Acceptance looks only at the registered count, so a same-cycle pop never
    // lets a write land on an entry that decode has not consumed yet.
    assign ib_allin    = (count_q <= CW'(DEPTH - 2));
    assign ib_valid_ns = (count_q != '0);

    always_comb begin
        pushEn  = if_ib_valid && ib_allin && if_ib_slot_valid[0];
        pushTwo = pushEn && if_ib_slot_valid[1];
        popEn   = ib_valid_ns && id_allin;
        pushCnt = pushTwo ? CW'(2) : (pushEn ? CW'(1) : '0);
        popCnt  = '0;
        if (popEn) begin
            popCnt = (count_q >= CW'(2)) ? CW'(2) : CW'(1);
        end
        head_d  = head_q + popCnt[AW-1:0];
        tail_d  = tail_q + pushCnt[AW-1:0];
        count_d = count_q + pushCnt - popCnt;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is cleared on reset so idle outputs read as zero.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < DEPTH; i++) begin
                pcMem_q[i]   <= '0;
                insnMem_q[i] <= '0;
                ptabMem_q[i] <= '0;
            end
            delotMem_q <= '0;
        end else if (pushEn && !flush) begin
            pcMem_q[tail_q]    <= if_ib_pc_0;
            insnMem_q[tail_q]  <= if_ib_insn_0;
            ptabMem_q[tail_q]  <= if_ib_ptab_addr_0;
            delotMem_q[tail_q] <= if_ib_delot_flag[0];
            if (pushTwo) begin
                pcMem_q[tailNext]    <= if_ib_pc_1;
                insnMem_q[tailNext]  <= if_ib_insn_1;
                ptabMem_q[tailNext]  <= if_ib_ptab_addr_1;
                delotMem_q[tailNext] <= if_ib_delot_flag[1];
            end
        end
    end

    assign ib_id_valid_0     = ib_valid_ns;
    assign ib_id_valid_1     = (count_q >= CW'(2));
    assign ib_id_pc_0        = pcMem_q[head_q];
    assign ib_id_pc_1        = pcMem_q[headNext];
    assign ib_id_insn_0      = insnMem_q[head_q];
    assign ib_id_insn_1      = insnMem_q[headNext];
    assign ib_id_ptab_addr_0 = ptabMem_q[head_q];
    assign ib_id_ptab_addr_1 = ptabMem_q[headNext];
    assign ib_id_delot_flag  = {delotMem_q[headNext] & ib_id_valid_1,
                                delotMem_q[head_q] & ib_id_valid_0};

endmodule

// File: tb/tb_insn_buffer.sv
// Self-checking bench for insn_buffer: directed scenarios followed by random
// traffic, all compared against a queue-based model of the instruction stream.
module tb_insn_buffer;

    localparam int DEPTH  = 8;
    localparam int PTAB_W = 5;

    logic              clk, clkEn, rst_, flush;
    logic              if_ib_valid;
    logic [1:0]        if_ib_slot_valid;
    logic [31:0]       if_ib_pc_0, if_ib_pc_1, if_ib_insn_0, if_ib_insn_1;
    logic [PTAB_W-1:0] if_ib_ptab_addr_0, if_ib_ptab_addr_1;
    logic [1:0]        if_ib_delot_flag;
    logic              ib_allin, id_allin, ib_valid_ns;
    logic [31:0]       ib_id_pc_0, ib_id_pc_1, ib_id_insn_0, ib_id_insn_1;
    logic [PTAB_W-1:0] ib_id_ptab_addr_0, ib_id_ptab_addr_1;
    logic              ib_id_valid_0, ib_id_valid_1;
    logic [1:0]        ib_id_delot_flag;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       insn;
        logic [PTAB_W-1:0] ptab;
        logic              delot;
    } entry_t;

    entry_t modelQ[$];
    int     passCount  = 0;
    int     totalCount = 0;
    logic [31:0] nextPc;

    insn_buffer #(.DEPTH(DEPTH), .PTAB_W(PTAB_W)) dut (
        .clk(clk), .rst_(rst_), .flush(flush),
        .if_ib_valid(if_ib_valid), .if_ib_slot_valid(if_ib_slot_valid),
        .if_ib_pc_0(if_ib_pc_0), .if_ib_pc_1(if_ib_pc_1),
        .if_ib_insn_0(if_ib_insn_0), .if_ib_insn_1(if_ib_insn_1),
        .if_ib_ptab_addr_0(if_ib_ptab_addr_0), .if_ib_ptab_addr_1(if_ib_ptab_addr_1),
        .if_ib_delot_flag(if_ib_delot_flag),
        .ib_allin(ib_allin), .id_allin(id_allin), .ib_valid_ns(ib_valid_ns),
        .ib_id_pc_0(ib_id_pc_0), .ib_id_pc_1(ib_id_pc_1),
        .ib_id_insn_0(ib_id_insn_0), .ib_id_insn_1(ib_id_insn_1),
        .ib_id_ptab_addr_0(ib_id_ptab_addr_0), .ib_id_ptab_addr_1(ib_id_ptab_addr_1),
        .ib_id_valid_0(ib_id_valid_0), .ib_id_valid_1(ib_id_valid_1),
        .ib_id_delot_flag(ib_id_delot_flag)
    );

    initial clk = 1'b0;
    always #5 if (clkEn) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        totalCount++;
        assert (obs === expv) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Outputs depend only on registered state, so the model's queue contents
    // fully determine what decode should see.
    task automatic checkOutput();
        int n;
        logic [1:0] expDelot;
        n = modelQ.size();
        expDelot = 2'b00;
        if (n >= 1) expDelot[0] = modelQ[0].delot;
        if (n >= 2) expDelot[1] = modelQ[1].delot;
        check("allin", ib_allin, (n <= DEPTH - 2));
        check("valid_ns", ib_valid_ns, (n >= 1));
        check("valid_0", ib_id_valid_0, (n >= 1));
        check("valid_1", ib_id_valid_1, (n >= 2));
        check("delot", ib_id_delot_flag, expDelot);
        if (n >= 1) begin
            check("pc_0", ib_id_pc_0, modelQ[0].pc);
            check("insn_0", ib_id_insn_0, modelQ[0].insn);
            check("ptab_0", ib_id_ptab_addr_0, modelQ[0].ptab);
        end
        if (n >= 2) begin
            check("pc_1", ib_id_pc_1, modelQ[1].pc);
            check("insn_1", ib_id_insn_1, modelQ[1].insn);
            check("ptab_1", ib_id_ptab_addr_1, modelQ[1].ptab);
        end
    endtask

    // One full cycle: check current outputs, drive a bundle, advance the model
    // at the clock edge, and return at the following falling edge.
    task automatic applyStimulus(input logic v, input logic [1:0] sv,
                                 input logic [31:0] pc0, input logic [31:0] pc1,
                                 input logic [1:0] dl, input logic idA, input logic fl);
        entry_t e0, e1;
        int n;
        logic acc;
        checkOutput();
        e0 = '{pc: pc0, insn: $urandom, ptab: PTAB_W'($urandom_range(0, 31)), delot: dl[0]};
        e1 = '{pc: pc1, insn: $urandom, ptab: PTAB_W'($urandom_range(0, 31)), delot: dl[1]};
        if_ib_valid       = v;
        if_ib_slot_valid  = sv;
        if_ib_pc_0        = e0.pc;
        if_ib_pc_1        = e1.pc;
        if_ib_insn_0      = e0.insn;
        if_ib_insn_1      = e1.insn;
        if_ib_ptab_addr_0 = e0.ptab;
        if_ib_ptab_addr_1 = e1.ptab;
        if_ib_delot_flag  = dl;
        id_allin          = idA;
        flush             = fl;
        n   = modelQ.size();
        acc = (n <= DEPTH - 2);
        @(posedge clk);
        if (fl) begin
            modelQ.delete();
        end else begin
            if (idA && n > 0) begin
                modelQ.delete(0);
                if (n >= 2) modelQ.delete(0);
            end
            if (v && acc && sv[0]) begin
                modelQ.push_back(e0);
                if (sv[1]) modelQ.push_back(e1);
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH && modelQ.size() > 0; i++)
            applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
    endtask

    initial begin
        clkEn = 1'b0;
        rst_  = 1'b1;
        flush = 1'b0;
        if_ib_valid = 1'b0; if_ib_slot_valid = 2'b00;
        if_ib_pc_0 = '0; if_ib_pc_1 = '0; if_ib_insn_0 = '0; if_ib_insn_1 = '0;
        if_ib_ptab_addr_0 = '0; if_ib_ptab_addr_1 = '0; if_ib_delot_flag = '0;
        id_allin = 1'b0;
        #1 rst_ = 1'b0;
        #2;
        $display("[TB] reset without clock");
        check("rst_valid_ns", ib_valid_ns, 1'b0);
        check("rst_allin", ib_allin, 1'b1);
        check("rst_valid", {ib_id_valid_1, ib_id_valid_0}, 2'b00);
        check("rst_pc0", ib_id_pc_0, 32'h0);
        check("rst_delot", ib_id_delot_flag, 2'b00);

        clkEn = 1'b1;
        @(negedge clk);
        rst_ = 1'b1;

        $display("[TB] first pair latency");
        applyStimulus(1'b1, 2'b11, 32'h100, 32'h104, 2'b00, 1'b0, 1'b0);
        check("first_valid", {ib_id_valid_1, ib_id_valid_0}, 2'b11);
        check("first_pc0", ib_id_pc_0, 32'h100);
        check("first_pc1", ib_id_pc_1, 32'h104);
        drain();
        check("drain_empty", ib_valid_ns, 1'b0);

        $display("[TB] single-slot bundles");
        applyStimulus(1'b1, 2'b01, 32'h200, 32'hDEAD, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b11, 32'h204, 32'h208, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
        check("single_pc0", ib_id_pc_0, 32'h208);
        check("single_valid1", ib_id_valid_1, 1'b0);
        drain();

        $display("[TB] fill to full");
        nextPc = 32'h300;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 2'b11, nextPc, nextPc + 4, 2'b00, 1'b0, 1'b0);
            nextPc += 8;
        end
        applyStimulus(1'b1, 2'b01, nextPc, 32'h0, 2'b00, 1'b0, 1'b0);
        nextPc += 4;
        check("full_allin", ib_allin, 1'b0);
        applyStimulus(1'b1, 2'b11, 32'hBAD0, 32'hBAD4, 2'b00, 1'b0, 1'b0);
        check("full_hold_allin", ib_allin, 1'b0);
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
        check("after_pop_allin", ib_allin, 1'b1);
        drain();

        $display("[TB] streaming across wrap");
        nextPc = 32'h1000;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 2'b11, nextPc, nextPc + 4, 2'b00, 1'b1, 1'b0);
            nextPc += 8;
        end
        check("stream_valid1", ib_id_valid_1, 1'b1);
        drain();

        $display("[TB] flush with concurrent traffic");
        applyStimulus(1'b1, 2'b11, 32'h400, 32'h404, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b11, 32'h408, 32'h40C, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 32'h410, 32'h0, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b11, 32'h414, 32'h418, 2'b00, 1'b1, 1'b1);
        check("flush_valid_ns", ib_valid_ns, 1'b0);
        check("flush_allin", ib_allin, 1'b1);

        $display("[TB] delay-slot flags");
        applyStimulus(1'b1, 2'b01, 32'h500, 32'h504, 2'b10, 1'b0, 1'b0);
        check("delot_masked", ib_id_delot_flag, 2'b00);
        drain();
        applyStimulus(1'b1, 2'b11, 32'h600, 32'h604, 2'b10, 1'b0, 1'b0);
        check("delot_pair", ib_id_delot_flag, 2'b10);
        drain();

        $display("[TB] asynchronous reset mid-operation");
        applyStimulus(1'b1, 2'b11, 32'h700, 32'h704, 2'b11, 1'b0, 1'b0);
        if_ib_valid = 1'b0;
        #2 rst_ = 1'b0;
        #1;
        modelQ.delete();
        check("arst_valid_ns", ib_valid_ns, 1'b0);
        check("arst_pc0", ib_id_pc_0, 32'h0);
        check("arst_insn1", ib_id_insn_1, 32'h0);
        checkOutput();
        @(negedge clk);
        rst_ = 1'b1;

        $display("[TB] random traffic");
        nextPc = 32'h8000;
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                          nextPc, nextPc + 4, 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
            nextPc += 8;
        end
        drain();
        checkOutput();

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
